// File: rtl/pipe_hazard_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_if
//   Bundles the ID-stage instruction information, the data-memory busy flag
//   and every control output of pipe_hazard_ctrl.
//
//   Flow control: there is no valid/ready pair on this bus. id_valid qualifies
//   the ID fields in the same cycle (id_valid=0 means a NOP). mem_busy is pure
//   back-pressure from the data memory: while it is high the controller freezes
//   everything upstream of WB. The enables and bubbles returned by the
//   controller are combinational and apply at the next rising clock edge.
//
//   master : pipeline datapath side (drives ID info, consumes enables/selects)
//   slave  : hazard controller side
//
//   ID info  : id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
//              id_regwrite, id_load, id_branch, id_taken
//   Memory   : mem_busy
//   Control  : pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, back_en,
//              wb_bubble, fwd_a_sel, fwd_b_sel
//   Counters : stall_cnt, flush_cnt
// ---------------------------------------------------------------------------
interface pipe_hazard_if #(
    parameter int MEM_STAGES = 1,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16,
    parameter int FW         = $clog2(MEM_STAGES + 2)
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_dst;
    logic              id_regwrite;
    logic              id_load;
    logic              id_branch;
    logic              id_taken;
    logic              mem_busy;

    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_en;
    logic              idex_bubble;
    logic              back_en;
    logic              wb_bubble;
    logic [FW-1:0]     fwd_a_sel;
    logic [FW-1:0]     fwd_b_sel;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
               id_regwrite, id_load, id_branch, id_taken, mem_busy,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, back_en,
               wb_bubble, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
               id_regwrite, id_load, id_branch, id_taken, mem_busy,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, back_en,
               wb_bubble, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard / forwarding controller for a MIPS pipeline IF, ID, EX, M1..MN, WB
//   with N = MEM_STAGES data-memory stages. It keeps a shadow copy of the
//   dest/regwrite/load info of every stage from EX to WB and derives from it
//   the PC and pipe-register enables, bubbles, the IF/ID flush, the EX
//   forwarding selects and two saturating performance counters.
//
//   Ports
//     Clk : clock
//     Rst : asynchronous, active-high reset
//     bus : pipe_hazard_if.slave (ID info in, control/selects/counters out)
//
//   Shadow positions: p0 = EX, p1..pN = M1..MN, p(N+1) = WB.
//   Forward select k means "take the result held in position p_k".
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MEM_STAGES = 1,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16,
    parameter int FW         = $clog2(MEM_STAGES + 2)
) (
    input  logic          Clk,
    input  logic          Rst,
    pipe_hazard_if.slave  bus
);
    localparam int NP = MEM_STAGES + 2;   // number of shadow positions
    localparam int WB = MEM_STAGES + 1;   // index of the WB position

    // Shadow state
    logic [NP-1:0]     valid_q, valid_d;
    logic [NP-1:0]     rw_q,    rw_d;
    logic [NP-1:0]     load_q,  load_d;
    logic [REG_AW-1:0] dst_q [NP];
    logic [REG_AW-1:0] dst_d [NP];
    logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d;
    logic              use_rs_q, use_rs_d, use_rt_q, use_rt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    // Hazard detection / control
    logic [NP-1:0]     hit_id;
    logic              load_stall, br_stall;
    logic              pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
    logic              back_en, wb_bubble;
    logic [FW-1:0]     fwd_a, fwd_b;

    // hit_id[k]: position k will write a register that the ID instruction
    // reads. r0 is never a real dependency.
    always_comb begin : hazard_detect
        hit_id     = '0;
        load_stall = 1'b0;
        br_stall   = 1'b0;
        for (int k = 0; k < NP; k++) begin
            if (valid_q[k] && rw_q[k] && (dst_q[k] != '0)) begin
                if ((bus.id_use_rs && (dst_q[k] == bus.id_rs)) ||
                    (bus.id_use_rt && (dst_q[k] == bus.id_rt))) begin
                    hit_id[k] = 1'b1;
                end
            end
        end
        // Load data only exists at WB, so a dependent instruction must wait
        // until the load has left the last memory stage.
        for (int k = 0; k < MEM_STAGES; k++) begin
            if (load_q[k] && hit_id[k]) begin
                load_stall = 1'b1;
            end
        end
        load_stall = load_stall && bus.id_valid;
        // Branches compare in ID from the register file, which is not
        // write-through: wait for the producer to leave WB entirely.
        br_stall = bus.id_valid && bus.id_branch && (|hit_id);
    end

    always_comb begin : control
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_bubble = 1'b0;
        back_en     = 1'b1;
        wb_bubble   = 1'b0;
        if (Rst) begin
            // keep reset values while reset is asserted
        end else if (bus.mem_busy) begin
            // Freeze everything up to MN; a pending redirect waits too.
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            back_en   = 1'b0;
            wb_bubble = 1'b1;
        end else if (load_stall || br_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end else if (bus.id_taken) begin
            ifid_flush = 1'b1;
        end
    end

    // Walk from WB down to M1 so the youngest eligible producer wins.
    // Loads are only forwarded from WB.
    always_comb begin : forwarding
        fwd_a = '0;
        fwd_b = '0;
        for (int k = WB; k >= 1; k--) begin
            if (valid_q[k] && rw_q[k] && (dst_q[k] != '0) &&
                (!load_q[k] || (k == WB))) begin
                if (use_rs_q && (dst_q[k] == rs_q)) begin
                    fwd_a = FW'(k);
                end
                if (use_rt_q && (dst_q[k] == rt_q)) begin
                    fwd_b = FW'(k);
                end
            end
        end
    end

    always_comb begin : next_state
        valid_d  = valid_q;
        rw_d     = rw_q;
        load_d   = load_q;
        dst_d    = dst_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        use_rs_d = use_rs_q;
        use_rt_d = use_rt_q;
        if (back_en) begin
            for (int k = 0; k < MEM_STAGES; k++) begin
                valid_d[k+1] = valid_q[k];
                rw_d[k+1]    = rw_q[k];
                load_d[k+1]  = load_q[k];
                dst_d[k+1]   = dst_q[k];
            end
            valid_d[0] = bus.id_valid && !idex_bubble;
            rw_d[0]    = bus.id_regwrite;
            load_d[0]  = bus.id_load;
            dst_d[0]   = bus.id_dst;
            rs_d       = bus.id_rs;
            rt_d       = bus.id_rt;
            use_rs_d   = bus.id_use_rs;
            use_rt_d   = bus.id_use_rt;
        end
        // MN/WB loads every cycle; during a memory stall it receives a NOP.
        valid_d[WB] = valid_q[MEM_STAGES] && !wb_bubble;
        rw_d[WB]    = rw_q[MEM_STAGES];
        load_d[WB]  = load_q[MEM_STAGES];
        dst_d[WB]   = dst_q[MEM_STAGES];

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (ifid_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            valid_q     <= '0;
            rw_q        <= '0;
            load_q      <= '0;
            for (int k = 0; k < NP; k++) begin
                dst_q[k] <= '0;
            end
            rs_q        <= '0;
            rt_q        <= '0;
            use_rs_q    <= 1'b0;
            use_rt_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            rw_q        <= rw_d;
            load_q      <= load_d;
            dst_q       <= dst_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            use_rs_q    <= use_rs_d;
            use_rt_q    <= use_rt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_en     = idex_en;
    assign bus.idex_bubble = idex_bubble;
    assign bus.back_en     = back_en;
    assign bus.wb_bubble   = wb_bubble;
    assign bus.fwd_a_sel   = fwd_a;
    assign bus.fwd_b_sel   = fwd_b;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Three controllers see identical ID
//   streams: u1 (N=1), u2 (N=2) and u3 (N=1 with 2-bit counters, used to see
//   counter saturation). Inputs change 1 time unit after a rising edge and
//   outputs are sampled 3 units later, well away from either clock edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_load;
    logic       id_branch, id_taken, mem_busy;
    logic [4:0] id_rs, id_rt, id_dst;

    pipe_hazard_if #(.MEM_STAGES(1))             if1 ();
    pipe_hazard_if #(.MEM_STAGES(2))             if2 ();
    pipe_hazard_if #(.MEM_STAGES(1), .CNT_W(2))  if3 ();

    assign if1.id_valid = id_valid;   assign if2.id_valid = id_valid;   assign if3.id_valid = id_valid;
    assign if1.id_rs = id_rs;         assign if2.id_rs = id_rs;         assign if3.id_rs = id_rs;
    assign if1.id_rt = id_rt;         assign if2.id_rt = id_rt;         assign if3.id_rt = id_rt;
    assign if1.id_use_rs = id_use_rs; assign if2.id_use_rs = id_use_rs; assign if3.id_use_rs = id_use_rs;
    assign if1.id_use_rt = id_use_rt; assign if2.id_use_rt = id_use_rt; assign if3.id_use_rt = id_use_rt;
    assign if1.id_dst = id_dst;       assign if2.id_dst = id_dst;       assign if3.id_dst = id_dst;
    assign if1.id_regwrite = id_regwrite; assign if2.id_regwrite = id_regwrite; assign if3.id_regwrite = id_regwrite;
    assign if1.id_load = id_load;     assign if2.id_load = id_load;     assign if3.id_load = id_load;
    assign if1.id_branch = id_branch; assign if2.id_branch = id_branch; assign if3.id_branch = id_branch;
    assign if1.id_taken = id_taken;   assign if2.id_taken = id_taken;   assign if3.id_taken = id_taken;
    assign if1.mem_busy = mem_busy;   assign if2.mem_busy = mem_busy;   assign if3.mem_busy = mem_busy;

    pipe_hazard_ctrl #(.MEM_STAGES(1))            u1 (.Clk(Clk), .Rst(Rst), .bus(if1));
    pipe_hazard_ctrl #(.MEM_STAGES(2))            u2 (.Clk(Clk), .Rst(Rst), .bus(if2));
    pipe_hazard_ctrl #(.MEM_STAGES(1), .CNT_W(2)) u3 (.Clk(Clk), .Rst(Rst), .bus(if3));

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] dst,
                          input logic rw, input logic ld, input logic br, input logic tk);
        id_valid = v;    id_rs = rs;       id_rt = rt;
        id_use_rs = urs; id_use_rt = urt;  id_dst = dst;
        id_regwrite = rw; id_load = ld;    id_branch = br; id_taken = tk;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_busy = 1'b0;
        repeat (6) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Rst = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_busy = 1'b0;
        #2;
        n_checks++; if ({if1.pc_en, if1.ifid_en, if1.idex_en, if1.back_en, if1.ifid_flush, if1.idex_bubble, if1.wb_bubble} !== 7'b1111000) begin n_fail++; $display("FAIL reset_ctrl_u1: got %b want 1111000", {if1.pc_en, if1.ifid_en, if1.idex_en, if1.back_en, if1.ifid_flush, if1.idex_bubble, if1.wb_bubble}); end
        n_checks++; if ({if2.pc_en, if2.ifid_en, if2.idex_en, if2.back_en, if2.ifid_flush, if2.idex_bubble, if2.wb_bubble} !== 7'b1111000) begin n_fail++; $display("FAIL reset_ctrl_u2: got %b want 1111000", {if2.pc_en, if2.ifid_en, if2.idex_en, if2.back_en, if2.ifid_flush, if2.idex_bubble, if2.wb_bubble}); end
        n_checks++; if ({if1.fwd_a_sel, if1.fwd_b_sel} !== 4'd0) begin n_fail++; $display("FAIL reset_fwd_u1: got %b want 0000", {if1.fwd_a_sel, if1.fwd_b_sel}); end
        n_checks++; if ({if1.stall_cnt, if1.flush_cnt} !== 32'd0) begin n_fail++; $display("FAIL reset_cnt_u1: got %h want 0", {if1.stall_cnt, if1.flush_cnt}); end
        @(negedge Clk);
        Rst = 1'b0;
        tick();
    endtask

    // lw r2,0(r1) followed by add r3,r2,r4
    task automatic test_load_use();
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 0);
        settle();
        n_checks++; if (if1.pc_en !== 1'b1) begin n_fail++; $display("FAIL lu_c0_pc_en_u1: got %b want 1", if1.pc_en); end
        tick();
        set_id(1, 5'd2, 5'd4, 1, 1, 5'd3, 1, 0, 0, 0);
        settle();
        n_checks++; if ({if1.pc_en, if1.idex_bubble, if1.ifid_flush, if1.back_en} !== 4'b0101) begin n_fail++; $display("FAIL lu_c1_stall_u1: got %b want 0101", {if1.pc_en, if1.idex_bubble, if1.ifid_flush, if1.back_en}); end
        n_checks++; if ({if2.pc_en, if2.idex_bubble} !== 2'b01) begin n_fail++; $display("FAIL lu_c1_stall_u2: got %b want 01", {if2.pc_en, if2.idex_bubble}); end
        tick();
        settle();
        n_checks++; if ({if1.pc_en, if1.idex_bubble} !== 2'b10) begin n_fail++; $display("FAIL lu_c2_release_u1: got %b want 10", {if1.pc_en, if1.idex_bubble}); end
        n_checks++; if ({if2.pc_en, if2.idex_bubble} !== 2'b01) begin n_fail++; $display("FAIL lu_c2_stall_u2: got %b want 01", {if2.pc_en, if2.idex_bubble}); end
        tick();
        settle();
        n_checks++; if (if1.fwd_a_sel !== 2'd2) begin n_fail++; $display("FAIL lu_fwd_a_u1: got %0d want 2", if1.fwd_a_sel); end
        n_checks++; if (if1.fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL lu_fwd_b_u1: got %0d want 0", if1.fwd_b_sel); end
        n_checks++; if (if1.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt_u1: got %0d want 1", if1.stall_cnt); end
        n_checks++; if (if2.pc_en !== 1'b1) begin n_fail++; $display("FAIL lu_c3_release_u2: got %b want 1", if2.pc_en); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        n_checks++; if (if2.fwd_a_sel !== 2'd3) begin n_fail++; $display("FAIL lu_fwd_a_u2: got %0d want 3", if2.fwd_a_sel); end
        n_checks++; if (if2.stall_cnt !== 16'd2) begin n_fail++; $display("FAIL lu_stall_cnt_u2: got %0d want 2", if2.stall_cnt); end
        drain();
    endtask

    // add r1,r6,r7 followed by sub r5,r1,r1
    task automatic test_alu_fwd();
        set_id(1, 5'd6, 5'd7, 1, 1, 5'd1, 1, 0, 0, 0);
        tick();
        set_id(1, 5'd1, 5'd1, 1, 1, 5'd5, 1, 0, 0, 0);
        settle();
        n_checks++; if (if2.pc_en !== 1'b1) begin n_fail++; $display("FAIL alu_no_stall_u2: got %b want 1", if2.pc_en); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        n_checks++; if ({if2.fwd_a_sel, if2.fwd_b_sel} !== 4'b0101) begin n_fail++; $display("FAIL alu_fwd_u2: got a=%0d b=%0d want a=1 b=1", if2.fwd_a_sel, if2.fwd_b_sel); end
        n_checks++; if ({if1.fwd_a_sel, if1.fwd_b_sel} !== 4'b0101) begin n_fail++; $display("FAIL alu_fwd_u1: got a=%0d b=%0d want a=1 b=1", if1.fwd_a_sel, if1.fwd_b_sel); end
        drain();
    endtask

    // lw r0 ; addi r0 ; beq r0,r0 : r0 never stalls nor forwards
    task automatic test_r0();
        set_id(1, 5'd3, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0);
        tick();
        set_id(1, 5'd3, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0);
        tick();
        set_id(1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 1, 0);
        settle();
        n_checks++; if (if1.pc_en !== 1'b1) begin n_fail++; $display("FAIL r0_no_stall_u1: got %b want 1", if1.pc_en); end
        n_checks++; if (if2.pc_en !== 1'b1) begin n_fail++; $display("FAIL r0_no_stall_u2: got %b want 1", if2.pc_en); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        n_checks++; if ({if1.fwd_a_sel, if1.fwd_b_sel} !== 4'd0) begin n_fail++; $display("FAIL r0_fwd_u1: got a=%0d b=%0d want 0", if1.fwd_a_sel, if1.fwd_b_sel); end
        drain();
    endtask

    // jump redirect held off by 3 busy cycles
    task automatic test_mem_busy();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        mem_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_checks++; if ({if1.pc_en, if1.ifid_en, if1.idex_en, if1.back_en, if1.wb_bubble, if1.ifid_flush} !== 6'b000010) begin n_fail++; $display("FAIL busy_c%0d_u1: got %b want 000010", c, {if1.pc_en, if1.ifid_en, if1.idex_en, if1.back_en, if1.wb_bubble, if1.ifid_flush}); end
            tick();
        end
        mem_busy = 1'b0;
        settle();
        n_checks++; if ({if1.pc_en, if1.ifid_flush} !== 2'b11) begin n_fail++; $display("FAIL busy_release_flush_u1: got %b want 11", {if1.pc_en, if1.ifid_flush}); end
        n_checks++; if (if1.stall_cnt !== 16'd4) begin n_fail++; $display("FAIL busy_stall_cnt_u1: got %0d want 4", if1.stall_cnt); end
        n_checks++; if (if3.stall_cnt !== 2'd3) begin n_fail++; $display("FAIL busy_stall_sat_u3: got %0d want 3", if3.stall_cnt); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        n_checks++; if (if1.ifid_flush !== 1'b0) begin n_fail++; $display("FAIL busy_flush_once_u1: got %b want 0", if1.ifid_flush); end
        n_checks++; if (if1.flush_cnt !== 16'd1) begin n_fail++; $display("FAIL busy_flush_cnt_u1: got %0d want 1", if1.flush_cnt); end
        drain();
    endtask

    // add r1 ; beq r1,r2 (taken once it resolves)
    task automatic test_branch();
        set_id(1, 5'd6, 5'd7, 1, 1, 5'd1, 1, 0, 0, 0);
        tick();
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 1, 0);
        for (int c = 0; c < 3; c++) begin
            settle();
            n_checks++; if ({if1.pc_en, if1.ifid_flush} !== 2'b00) begin n_fail++; $display("FAIL br_stall_c%0d_u1: got %b want 00", c, {if1.pc_en, if1.ifid_flush}); end
            tick();
        end
        id_taken = 1'b1;
        settle();
        n_checks++; if ({if1.pc_en, if1.ifid_flush} !== 2'b11) begin n_fail++; $display("FAIL br_resolve_u1: got %b want 11", {if1.pc_en, if1.ifid_flush}); end
        n_checks++; if (if1.stall_cnt !== 16'd7) begin n_fail++; $display("FAIL br_stall_cnt_u1: got %0d want 7", if1.stall_cnt); end
        n_checks++; if (if3.stall_cnt !== 2'd3) begin n_fail++; $display("FAIL br_stall_sat_u3: got %0d want 3", if3.stall_cnt); end
        tick();
        drain();
    endtask

    // asynchronous reset in the middle of a load-use stall
    task automatic test_rst_mid_stall();
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 0);
        tick();
        set_id(1, 5'd2, 5'd4, 1, 1, 5'd3, 1, 0, 0, 0);
        #2;
        n_checks++; if (if1.pc_en !== 1'b0) begin n_fail++; $display("FAIL rst_pre_stall_u1: got %b want 0", if1.pc_en); end
        #1;
        Rst = 1'b1;
        #1;
        n_checks++; if ({if1.pc_en, if1.idex_bubble} !== 2'b10) begin n_fail++; $display("FAIL rst_async_ctrl_u1: got %b want 10", {if1.pc_en, if1.idex_bubble}); end
        n_checks++; if ({if1.stall_cnt, if1.flush_cnt} !== 32'd0) begin n_fail++; $display("FAIL rst_async_cnt_u1: got %h want 0", {if1.stall_cnt, if1.flush_cnt}); end
        n_checks++; if (if2.pc_en !== 1'b1) begin n_fail++; $display("FAIL rst_async_ctrl_u2: got %b want 1", if2.pc_en); end
        #2;
        Rst = 1'b0;
        tick();
        settle();
        n_checks++; if (if1.pc_en !== 1'b1) begin n_fail++; $display("FAIL rst_after_u1: got %b want 1", if1.pc_en); end
        drain();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_r0();
        test_mem_busy();
        test_branch();
        test_rst_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
